// File: rtl/discharge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : discharge_pkg
//  Description : State codes, waveform mode-bit indices and duration helper
//                shared by the discharge sequencer and the breakdown detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package discharge_pkg;

    typedef enum logic [7:0] {
        S_IDLE            = 8'h00,
        S_WAIT_BREAKDOWN  = 8'h01,
        S_BUCK_INTERLEAVE = 8'h02,
        S_RES_DISCHARGE   = 8'h04,
        S_DEION           = 8'h80
    } state_t;

    localparam int c_WF_BUCK_BIT       = 15;
    localparam int c_WF_CONTINUOUS_BIT = 14;
    localparam int c_WF_OPEN_BIT       = 13;

    // Terminal count for a duration counter starting at 0; a zero duration
    // behaves as a one-cycle duration.
    function automatic logic [15:0] duration_last(input logic [15:0] cycles);
        return (cycles == 16'd0) ? 16'd0 : cycles - 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buck_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : buck_phase_gen
//  Description : Two-phase interleaved buck gate generator; phase restarts at
//                0 whenever enable rises and wraps modulo period.
//  Revision    : 1.0 - initial release
// ============================================================================
module buck_phase_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] period,
    output logic [1:0]  gate
);

    logic [15:0] r_phase;
    logic [1:0]  r_gate;
    logic [15:0] w_half;
    logic        w_wrap;

    assign w_half = period >> 1;
    assign w_wrap = (r_phase >= period - 16'd1);

    // enable is the registered-next view of the buck state, so the gate
    // registered here lines up with the state register of the parent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 16'd0;
            r_gate  <= 2'b00;
        end else if (!enable) begin
            r_phase <= 16'd0;
            r_gate  <= 2'b00;
        end else begin
            r_gate  <= (r_phase < w_half) ? 2'b01 : 2'b10;
            r_phase <= w_wrap ? 16'd0 : r_phase + 16'd1;
        end
    end

    assign gate = r_gate;

endmodule
`default_nettype wire

// File: rtl/discharge_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : discharge_sequencer
//  Description : Gap discharge sequencer: waits for breakdown, drives buck or
//                resistor discharge for on_time, then deionises for off_time.
//  Revision    : 1.0 - initial release
// ============================================================================
module discharge_sequencer
    import discharge_pkg::*;
#(
    parameter logic [31:0] WAIT_TIMEOUT = 32'd100000,
    parameter logic [15:0] BUCK_PERIOD  = 16'd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_breakdown,
    input  logic [15:0] waveform,
    input  logic        start,
    input  logic [15:0] on_time,
    input  logic [15:0] off_time,
    output logic [7:0]  current_state,
    output logic [31:0] timer_wait_breakdown,
    output logic        main_gate,
    output logic [1:0]  buck_gate,
    output logic        res_gate,
    output logic        pulse_done,
    output logic        open_timeout
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_timer;
    logic [31:0] w_timer_next;
    logic [15:0] r_dur_cnt;
    logic [15:0] r_dur_last;
    logic        r_main_gate;
    logic        r_res_gate;
    logic        r_pulse_done;
    logic        r_open_timeout;
    logic        w_pulse_done;
    logic        w_open_timeout;
    logic        w_dur_done;
    logic        w_wf_buck;
    logic        w_wf_cont;
    logic        w_wf_open;
    logic        w_unused;

    assign w_wf_buck  = waveform[c_WF_BUCK_BIT];
    assign w_wf_cont  = waveform[c_WF_CONTINUOUS_BIT];
    assign w_wf_open  = waveform[c_WF_OPEN_BIT];
    assign w_unused   = &{1'b0, waveform[12:0]};
    assign w_dur_done = (r_dur_cnt == r_dur_last);

    // ------------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_pulse_done   = 1'b0;
        w_open_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wf_open && (w_wf_cont || start))
                    w_next_state = S_WAIT_BREAKDOWN;
            end
            S_WAIT_BREAKDOWN: begin
                // Clearing the open bit aborts before breakdown or timeout.
                if (!w_wf_open) begin
                    w_next_state = S_DEION;
                end else if (is_breakdown) begin
                    w_next_state = w_wf_buck ? S_BUCK_INTERLEAVE : S_RES_DISCHARGE;
                end else if (r_timer == WAIT_TIMEOUT - 32'd1) begin
                    w_next_state   = S_DEION;
                    w_open_timeout = 1'b1;
                end
            end
            S_BUCK_INTERLEAVE, S_RES_DISCHARGE: begin
                if (!w_wf_open) begin
                    w_next_state = S_DEION;
                end else if (w_dur_done) begin
                    w_next_state = S_DEION;
                    w_pulse_done = 1'b1;
                end
            end
            S_DEION: begin
                if (w_dur_done)
                    w_next_state = (w_wf_open && w_wf_cont) ? S_WAIT_BREAKDOWN : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_timer_next = 32'd0;
        if (w_next_state == S_WAIT_BREAKDOWN && r_state == S_WAIT_BREAKDOWN)
            w_timer_next = (r_timer == 32'hFFFF_FFFF) ? r_timer : r_timer + 32'd1;
    end

    // ------------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_timer        <= 32'd0;
            r_dur_cnt      <= 16'd0;
            r_dur_last     <= 16'd0;
            r_main_gate    <= 1'b0;
            r_res_gate     <= 1'b0;
            r_pulse_done   <= 1'b0;
            r_open_timeout <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_timer        <= w_timer_next;
            r_pulse_done   <= w_pulse_done;
            r_open_timeout <= w_open_timeout;
            r_main_gate    <= (w_next_state == S_WAIT_BREAKDOWN)
                           || (w_next_state == S_BUCK_INTERLEAVE)
                           || (w_next_state == S_RES_DISCHARGE);
            r_res_gate     <= (w_next_state == S_RES_DISCHARGE);

            // Durations are latched on entry so later edits apply next visit.
            if (w_next_state != r_state) begin
                r_dur_cnt <= 16'd0;
                case (w_next_state)
                    S_BUCK_INTERLEAVE, S_RES_DISCHARGE: r_dur_last <= duration_last(on_time);
                    S_DEION:                            r_dur_last <= duration_last(off_time);
                    default:                            r_dur_last <= 16'd0;
                endcase
            end else if (r_state == S_BUCK_INTERLEAVE || r_state == S_RES_DISCHARGE
                         || r_state == S_DEION) begin
                r_dur_cnt <= r_dur_cnt + 16'd1;
            end
        end
    end

    buck_phase_gen u_buck_phase_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (w_next_state == S_BUCK_INTERLEAVE),
        .period (BUCK_PERIOD),
        .gate   (buck_gate)
    );

    assign current_state        = r_state;
    assign timer_wait_breakdown = r_timer;
    assign main_gate            = r_main_gate;
    assign res_gate             = r_res_gate;
    assign pulse_done           = r_pulse_done;
    assign open_timeout         = r_open_timeout;

endmodule
`default_nettype wire

// File: tb/tb_discharge_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_discharge_sequencer
//  Description : Directed self-checking bench for discharge_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_discharge_sequencer;

    localparam logic [7:0] c_IDLE = 8'h00;
    localparam logic [7:0] c_WAIT = 8'h01;
    localparam logic [7:0] c_BUCK = 8'h02;
    localparam logic [7:0] c_RES  = 8'h04;
    localparam logic [7:0] c_DEI  = 8'h80;

    logic        clk;
    logic        rst_n;
    logic        is_breakdown;
    logic [15:0] waveform;
    logic        start;
    logic [15:0] on_time;
    logic [15:0] off_time;
    logic [7:0]  current_state;
    logic [31:0] timer_wait_breakdown;
    logic        main_gate;
    logic [1:0]  buck_gate;
    logic        res_gate;
    logic        pulse_done;
    logic        open_timeout;

    int checks;
    int errors;

    discharge_sequencer #(
        .WAIT_TIMEOUT (32'd1000),
        .BUCK_PERIOD  (16'd100)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .is_breakdown         (is_breakdown),
        .waveform             (waveform),
        .start                (start),
        .on_time              (on_time),
        .off_time             (off_time),
        .current_state        (current_state),
        .timer_wait_breakdown (timer_wait_breakdown),
        .main_gate            (main_gate),
        .buck_gate            (buck_gate),
        .res_gate             (res_gate),
        .pulse_done           (pulse_done),
        .open_timeout         (open_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        int n;
        waveform = 16'h0000; is_breakdown = 1'b0; start = 1'b0;
        n = 0;
        while (current_state !== c_IDLE && n < 1000) begin step(); n++; end
        checks++;
        if (current_state !== c_IDLE) begin
            errors++; $display("FAIL go_idle: state=%h required=%h", current_state, c_IDLE);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; is_breakdown = 1'b0; waveform = 16'h0000; start = 1'b0;
        on_time = 16'd0; off_time = 16'd0;
        #12;
        checks++;
        if ({current_state, timer_wait_breakdown, main_gate, buck_gate, res_gate, pulse_done, open_timeout} !== 46'd0) begin
            errors++; $display("FAIL reset_outputs: state=%h timer=%0d gates=%b%b%b strobes=%b%b required all zero",
                current_state, timer_wait_breakdown, main_gate, buck_gate, res_gate, pulse_done, open_timeout);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (current_state !== c_IDLE) begin
            errors++; $display("FAIL reset_idle_hold: state=%h required=%h", current_state, c_IDLE);
        end
    endtask

    task automatic test_continuous_res();
        int n;
        waveform = 16'h6000; on_time = 16'd50; off_time = 16'd200;
        step();
        checks++;
        if (current_state !== c_WAIT || timer_wait_breakdown !== 32'd0 || main_gate !== 1'b1) begin
            errors++; $display("FAIL cont_wait_entry: state=%h timer=%0d main=%b required 01/0/1",
                current_state, timer_wait_breakdown, main_gate);
        end
        repeat (29) step();
        checks++;
        if (timer_wait_breakdown !== 32'd29) begin
            errors++; $display("FAIL cont_timer_29: timer=%0d required=29", timer_wait_breakdown);
        end
        is_breakdown = 1'b1;
        step();
        is_breakdown = 1'b0;
        on_time = 16'd10;
        checks++;
        if (current_state !== c_RES || timer_wait_breakdown !== 32'd0 || res_gate !== 1'b1 || buck_gate !== 2'b00) begin
            errors++; $display("FAIL cont_res_entry: state=%h timer=%0d res=%b buck=%b required 04/0/1/00",
                current_state, timer_wait_breakdown, res_gate, buck_gate);
        end
        n = 0;
        while (current_state === c_RES && n < 100) begin
            if (res_gate !== 1'b1 || main_gate !== 1'b1) n = n + 1000;
            n++; step();
        end
        checks++;
        if (n !== 50) begin
            errors++; $display("FAIL cont_res_length: cycles=%0d required=50", n);
        end
        checks++;
        if (current_state !== c_DEI || pulse_done !== 1'b1 || main_gate !== 1'b0 || res_gate !== 1'b0) begin
            errors++; $display("FAIL cont_deion_entry: state=%h pulse_done=%b main=%b res=%b required 80/1/0/0",
                current_state, pulse_done, main_gate, res_gate);
        end
        on_time = 16'd50;
        n = 0;
        while (current_state === c_DEI && n < 400) begin
            if (n == 1 && pulse_done !== 1'b0) n = n + 1000;
            n++; step();
        end
        checks++;
        if (n !== 200) begin
            errors++; $display("FAIL cont_deion_length: cycles=%0d required=200", n);
        end
        checks++;
        if (current_state !== c_WAIT || timer_wait_breakdown !== 32'd0) begin
            errors++; $display("FAIL cont_rewait: state=%h timer=%0d required 01/0", current_state, timer_wait_breakdown);
        end
        go_idle();
    endtask

    task automatic test_buck();
        int n;
        int bad;
        logic [1:0] exp_gate;
        waveform = 16'hE000; on_time = 16'd250; off_time = 16'd5;
        step();
        is_breakdown = 1'b1;
        step();
        is_breakdown = 1'b0;
        n = 0; bad = 0;
        while (current_state === c_BUCK && n < 400) begin
            exp_gate = ((n % 100) < 50) ? 2'b01 : 2'b10;
            if (buck_gate !== exp_gate || main_gate !== 1'b1 || res_gate !== 1'b0) bad++;
            n++; step();
        end
        checks++;
        if (n !== 250) begin
            errors++; $display("FAIL buck_length: cycles=%0d required=250", n);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL buck_sequence: bad_cycles=%0d required=0", bad);
        end
        checks++;
        if (current_state !== c_DEI || buck_gate !== 2'b00 || pulse_done !== 1'b1) begin
            errors++; $display("FAIL buck_exit: state=%h buck=%b pulse_done=%b required 80/00/1",
                current_state, buck_gate, pulse_done);
        end
        go_idle();
    endtask

    task automatic test_open_gap();
        int n;
        int bad;
        logic [31:0] last_timer;
        waveform = 16'h6000; off_time = 16'd5; is_breakdown = 1'b0;
        step();
        n = 0; bad = 0; last_timer = 32'd0;
        while (current_state === c_WAIT && n < 2000) begin
            if (open_timeout !== 1'b0 || pulse_done !== 1'b0) bad++;
            last_timer = timer_wait_breakdown;
            n++; step();
        end
        checks++;
        if (n !== 1000 || last_timer !== 32'd999) begin
            errors++; $display("FAIL open_wait_length: cycles=%0d last_timer=%0d required 1000/999", n, last_timer);
        end
        checks++;
        if (current_state !== c_DEI || open_timeout !== 1'b1 || pulse_done !== 1'b0 || main_gate !== 1'b0) begin
            errors++; $display("FAIL open_timeout_strobe: state=%h open_timeout=%b pulse_done=%b main=%b required 80/1/0/0",
                current_state, open_timeout, pulse_done, main_gate);
        end
        step();
        if (open_timeout !== 1'b0 || pulse_done !== 1'b0) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL open_strobes_quiet: bad_cycles=%0d required=0", bad);
        end
        go_idle();
    endtask

    task automatic test_single();
        int n;
        waveform = 16'h2000; on_time = 16'd3; off_time = 16'd4; start = 1'b0;
        repeat (5) step();
        checks++;
        if (current_state !== c_IDLE || main_gate !== 1'b0) begin
            errors++; $display("FAIL single_idle_wait: state=%h main=%b required 00/0", current_state, main_gate);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (current_state !== c_WAIT) begin
            errors++; $display("FAIL single_start: state=%h required=%h", current_state, c_WAIT);
        end
        is_breakdown = 1'b1;
        step();
        is_breakdown = 1'b0;
        start = 1'b1;
        n = 0;
        while (current_state === c_RES && n < 20) begin n++; step(); start = 1'b0; end
        checks++;
        if (n !== 3 || current_state !== c_DEI) begin
            errors++; $display("FAIL single_res_length: cycles=%0d state=%h required 3/80", n, current_state);
        end
        n = 0;
        while (current_state === c_DEI && n < 20) begin n++; step(); end
        checks++;
        if (n !== 4 || current_state !== c_IDLE) begin
            errors++; $display("FAIL single_deion_to_idle: cycles=%0d state=%h required 4/00", n, current_state);
        end
        repeat (5) step();
        checks++;
        if (current_state !== c_IDLE) begin
            errors++; $display("FAIL single_no_retrigger: state=%h required=%h", current_state, c_IDLE);
        end
        go_idle();
    endtask

    task automatic test_bit13_clear();
        int n;
        waveform = 16'h6000; on_time = 16'd50; off_time = 16'd5;
        step();
        is_breakdown = 1'b1;
        step();
        is_breakdown = 1'b0;
        repeat (5) step();
        waveform = 16'h4000;
        step();
        checks++;
        if (current_state !== c_DEI || main_gate !== 1'b0 || res_gate !== 1'b0 || pulse_done !== 1'b0) begin
            errors++; $display("FAIL bit13_abort: state=%h main=%b res=%b pulse_done=%b required 80/0/0/0",
                current_state, main_gate, res_gate, pulse_done);
        end
        n = 0;
        while (current_state === c_DEI && n < 20) begin n++; step(); end
        checks++;
        if (n !== 5 || current_state !== c_IDLE) begin
            errors++; $display("FAIL bit13_deion_idle: cycles=%0d state=%h required 5/00", n, current_state);
        end
        go_idle();
    endtask

    task automatic test_same_cycle();
        waveform = 16'h6000; on_time = 16'd4; off_time = 16'd5;
        step();
        repeat (999) step();
        checks++;
        if (current_state !== c_WAIT || timer_wait_breakdown !== 32'd999) begin
            errors++; $display("FAIL tie_setup: state=%h timer=%0d required 01/999", current_state, timer_wait_breakdown);
        end
        is_breakdown = 1'b1;
        step();
        is_breakdown = 1'b0;
        checks++;
        if (current_state !== c_RES || open_timeout !== 1'b0) begin
            errors++; $display("FAIL tie_breakdown_wins: state=%h open_timeout=%b required 04/0", current_state, open_timeout);
        end
        go_idle();
    endtask

    task automatic test_on_zero();
        int n;
        waveform = 16'h6000; on_time = 16'd0; off_time = 16'd3;
        step();
        is_breakdown = 1'b1;
        step();
        is_breakdown = 1'b0;
        n = 0;
        while (current_state === c_RES && n < 20) begin n++; step(); end
        checks++;
        if (n !== 1 || pulse_done !== 1'b1) begin
            errors++; $display("FAIL on_zero_length: cycles=%0d pulse_done=%b required 1/1", n, pulse_done);
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        waveform = 16'h6000; on_time = 16'd50; off_time = 16'd5;
        step();
        is_breakdown = 1'b1;
        step();
        is_breakdown = 1'b0;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (main_gate !== 1'b0 || res_gate !== 1'b0 || current_state !== c_IDLE) begin
            errors++; $display("FAIL async_reset_gates: state=%h main=%b res=%b required 00/0/0",
                current_state, main_gate, res_gate);
        end
        waveform = 16'h0000;
        #1 rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_continuous_res();
        test_buck();
        test_open_gap();
        test_single();
        test_bit13_clear();
        test_same_cycle();
        test_on_zero();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/discharge_sequencer.md
DISCHARGE_SEQUENCER -- requirements
Module: discharge_sequencer

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 32'd100000: cycles in S_WAIT_BREAKDOWN before open-gap abort.
REQ-002 Parameter BUCK_PERIOD, default 16'd100: buck interleave period in cycles; even, at least 2.
REQ-003 clk  in  1  100 MHz system clock.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 is_breakdown  in  1  breakdown flag from the breakdown detector.
REQ-006 waveform  in  16  mode word: bit15 buck(1)/resistor(0); bit14 continuous(1)/single(0); bit13 open(1)/closed(0).
REQ-007 start  in  1  single-shot trigger pulse, used only in single mode.
REQ-008 on_time  in  16  discharge duration in cycles; 0 is treated as 1.
REQ-009 off_time  in  16  deionisation duration in cycles; 0 is treated as 1.
REQ-010 current_state  out  8  state code, drives the breakdown detector.
REQ-011 timer_wait_breakdown  out  32  cycles spent in the current S_WAIT_BREAKDOWN visit.
REQ-012 main_gate  out  1  gap-voltage MOSFET enable.
REQ-013 buck_gate  out  2  interleaved buck MOSFET enables.
REQ-014 res_gate  out  1  resistor-discharge MOSFET enable.
REQ-015 pulse_done  out  1  one-cycle strobe at the end of each discharge.
REQ-016 open_timeout  out  1  one-cycle strobe on a wait timeout.

Function
REQ-017 State codes: S_IDLE 8'h00, S_WAIT_BREAKDOWN 8'h01, S_BUCK_INTERLEAVE 8'h02, S_RES_DISCHARGE 8'h04, S_DEION 8'h80.
REQ-018 S_IDLE transitions:
- bit13=1 and bit14=1: go to S_WAIT_BREAKDOWN.
- bit13=1, bit14=0, start=1: go to S_WAIT_BREAKDOWN.
- otherwise stay in S_IDLE.
REQ-019 S_WAIT_BREAKDOWN counting: timer_wait_breakdown is 0 on the first cycle in the state, increments by 1 per cycle, and saturates at 32'hFFFFFFFF.
REQ-020 S_WAIT_BREAKDOWN exits:
- is_breakdown=1: go to S_BUCK_INTERLEAVE if bit15=1, else S_RES_DISCHARGE; bit15 is sampled on that cycle.
- timer_wait_breakdown == WAIT_TIMEOUT-1 with is_breakdown=0: go to S_DEION and pulse open_timeout.
- is_breakdown and timeout on the same cycle: breakdown wins.
REQ-021 Discharge states: a duration counter runs from entry; after exactly max(on_time,1) cycles, go to S_DEION and pulse pulse_done on the transition edge.
REQ-022 S_DEION: hold for exactly max(off_time,1) cycles; then go to S_WAIT_BREAKDOWN if bit13=1 and bit14=1, else S_IDLE.
REQ-023 is_breakdown is ignored in every state except S_WAIT_BREAKDOWN.
REQ-024 Gate decode:
- main_gate=1 in S_WAIT_BREAKDOWN, S_BUCK_INTERLEAVE and S_RES_DISCHARGE.
- res_gate=1 only in S_RES_DISCHARGE.
- All gates 0 in S_IDLE and S_DEION.
REQ-025 buck_gate in S_BUCK_INTERLEAVE:
- phase counter starts at 0 on entry and wraps modulo BUCK_PERIOD.
- buck_gate[0]=1 while phase < BUCK_PERIOD/2; buck_gate[1]=1 otherwise.
- The two bits are never 1 together.
REQ-026 All outputs are registered; current_state and the gates change on the same clock edge.
REQ-027 on_time and off_time are sampled on state entry; changes mid-state take effect on the next entry.
REQ-028 waveform bit13 falling to 0 in S_WAIT_BREAKDOWN, S_BUCK_INTERLEAVE or S_RES_DISCHARGE forces S_DEION on the next edge with gates off; pulse_done is not asserted; S_DEION then completes and exits to S_IDLE.
REQ-029 start is ignored outside S_IDLE and in continuous mode.

Reset
REQ-030 On rst_n low, asynchronously:
- current_state=S_IDLE; timer_wait_breakdown=0.
- main_gate, buck_gate, res_gate, pulse_done, open_timeout all 0.
- All internal counters 0.
REQ-031 Reset asserted mid-discharge turns all gates off immediately, without waiting for a clock edge.

Structure
REQ-032 State codes and the waveform bit indices (15/14/13) are defined in shared package discharge_pkg, which the breakdown detector also uses.
REQ-033 The buck phase counter and buck_gate decode are placed in sub-module buck_phase_gen, with inputs enable and period and output gate[1:0].

Verification
REQ-034 Continuous resistor mode (waveform=16'h6000, on_time=50, off_time=200), is_breakdown after 30 wait cycles:
- res_gate high for exactly 50 cycles, then S_DEION for 200 cycles, then S_WAIT_BREAKDOWN again.
- timer_wait_breakdown reaches 29 and then reads 0 after the wait state exits.
REQ-035 Buck mode (waveform=16'hE000, BUCK_PERIOD=100, on_time=250): buck_gate sequence 01 for 50 cycles, 10 for 50, repeating; 2.5 periods total, never 11.
REQ-036 Open gap (WAIT_TIMEOUT=1000, is_breakdown held 0): open_timeout pulses once on the 1000th wait cycle, followed by S_DEION; pulse_done never asserts.
REQ-037 Single mode (waveform=16'h2000): stays in S_IDLE until start; one complete pulse, then S_IDLE; a second start during the discharge is ignored.
REQ-038 Corner cases:
- bit13 cleared mid-discharge: gates 0 on the next edge, S_DEION, then S_IDLE.
- is_breakdown and timeout on the same cycle: discharge entered, open_timeout stays 0.
- on_time=0: exactly one discharge cycle.
